mem_refill_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sequences each transaction as one line-aligned burst of LINE_WORDS beats.
- Uses round-robin arbitration so neither cache starves.
- Sits between i_cache/d_cache miss handlers and the memory model; cache-side data returns mirror cache_output_ifc valid/data semantics.

---
 rtl/mem_refill_arbiter_pkg.sv | 25 ++
 rtl/mem_refill_arbiter_if.sv | 50 +++++
 rtl/mem_refill_arbiter_rr_arbiter2.sv | 29 ++
 rtl/mem_refill_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_refill_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_refill_arbiter_pkg.sv
// Shared types for the I/D refill arbiter: FSM states, port owner, line geometry.
package mem_refill_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_READ,
    ARB_WRITE
  } arb_state_e;

  typedef enum logic {
    OWNER_I,
    OWNER_D
  } mem_owner_e;

  // Mirrors the cache line size in words.
  localparam int unsigned DefLineWords = 4;

  // Number of low address bits covered by one line.
  function automatic int unsigned line_offset_bits(int unsigned line_words,
                                                   int unsigned data_width);
    return $clog2(line_words) + $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/mem_refill_arbiter_if.sv
// Cache-side and memory-side signals of the refill arbiter.
// master: the arbiter's view; slave: the caches/memory environment.
interface mem_refill_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_done;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_wready;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_done;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  mem_ack, mem_wready, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_done,
    output d_wready, d_gnt, d_rvalid, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output mem_ack, mem_wready, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_done,
    input  d_wready, d_gnt, d_rvalid, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_refill_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick between the I and D requesters.
module mem_refill_arbiter_rr_arbiter2
  import mem_refill_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
  input  mem_owner_e last_owner,
  input  logic       mask,
  output logic       valid,
  output mem_owner_e owner
);

  logic i_elig;
  logic d_elig;

  // The just-served requester sits out one cycle while its req drops.
  always_comb begin
    i_elig = i_req & ~(mask & (last_owner == OWNER_I));
    d_elig = d_req & ~(mask & (last_owner == OWNER_D));
    valid  = i_elig | d_elig;
    owner  = OWNER_I;
    if (i_elig && d_elig) begin
      owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_elig) begin
      owner = OWNER_D;
    end
  end

endmodule

// File: rtl/mem_refill_arbiter.sv
// Shares one burst memory port between I-cache refills and D-cache refill/writeback.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = DefLineWords
) (
  input logic                clk,
  input logic                rst,
  mem_refill_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(LINE_WORDS);
  localparam int unsigned OffW = line_offset_bits(LINE_WORDS, DATA_WIDTH);
  localparam logic [CntW-1:0] LastBeat = CntW'(LINE_WORDS - 1);

  arb_state_e            state_q, state_d;
  mem_owner_e            owner_q, owner_d;
  mem_owner_e            last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  mask_q, mask_d;
  logic                  gnt_q, gnt_d;

  logic                  pick_valid;
  mem_owner_e            pick_owner;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  beat;
  logic                  done;

  mem_refill_arbiter_rr_arbiter2 u_rr (
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .last_owner(last_q),
    .mask      (mask_q),
    .valid     (pick_valid),
    .owner     (pick_owner)
  );

  // State register; reset abandons any burst without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_I;
      last_q  <= OWNER_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic and all port outputs.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    mask_d   = 1'b0;
    gnt_d    = 1'b0;
    beat     = 1'b0;
    sel_addr = (pick_owner == OWNER_D) ? bus.d_addr : bus.i_addr;
    sel_addr[OffW-1:0] = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_owner;
          we_d    = (pick_owner == OWNER_D) & bus.d_we;
          addr_d  = sel_addr;
          gnt_d   = 1'b1;
          state_d = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (bus.mem_ack) state_d = we_q ? ARB_WRITE : ARB_READ;
      end
      ARB_READ:  beat = bus.mem_rvalid;
      ARB_WRITE: beat = bus.mem_wready;
      default:   state_d = ARB_IDLE;
    endcase

    done = beat && (cnt_q == LastBeat);
    if (beat) begin
      if (done) begin
        cnt_d   = '0;
        last_d  = owner_q;
        mask_d  = 1'b1;
        state_d = ARB_IDLE;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    bus.mem_req   = (state_q == ARB_ADDR);
    bus.mem_we    = we_q & (state_q != ARB_IDLE);
    bus.mem_addr  = (state_q != ARB_IDLE) ? addr_q : '0;
    bus.mem_wdata = (state_q == ARB_WRITE) ? bus.d_wdata : '0;
    bus.d_wready  = (state_q == ARB_WRITE) & bus.mem_wready;

    bus.i_gnt    = gnt_q & (owner_q == OWNER_I);
    bus.d_gnt    = gnt_q & (owner_q == OWNER_D);
    bus.i_rvalid = (state_q == ARB_READ) & bus.mem_rvalid & (owner_q == OWNER_I);
    bus.d_rvalid = (state_q == ARB_READ) & bus.mem_rvalid & (owner_q == OWNER_D);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
    bus.i_done   = done & (owner_q == OWNER_I);
    bus.d_done   = done & (owner_q == OWNER_D);
  end

  // Requesters must hold req until their burst completes.
  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q != ARB_IDLE && owner_q == OWNER_I) |-> bus.i_req);
  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q != ARB_IDLE && owner_q == OWNER_D) |-> bus.d_req);

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter: refills, round-robin, writeback, reset, stray events.
module tb_mem_refill_arbiter;

  localparam logic [8:0] I_GNT = 9'h100;
  localparam logic [8:0] I_RV  = 9'h080;
  localparam logic [8:0] I_DN  = 9'h040;
  localparam logic [8:0] D_WR  = 9'h020;
  localparam logic [8:0] D_GNT = 9'h010;
  localparam logic [8:0] D_RV  = 9'h008;
  localparam logic [8:0] D_DN  = 9'h004;
  localparam logic [8:0] M_REQ = 9'h002;
  localparam logic [8:0] M_WE  = 9'h001;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_refill_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_refill_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .LINE_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctrl();
    return {bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_wready, bus.d_gnt,
            bus.d_rvalid, bus.d_done, bus.mem_req, bus.mem_we};
  endfunction

  // Four back-to-back read beats starting the cycle after mem_ack.
  task automatic read_burst(input bit to_d, input logic [31:0] base);
    logic [8:0] exp;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(b);
      #1;
      if (to_d) exp = D_RV | ((b == 3) ? D_DN : 9'h0);
      else      exp = I_RV | ((b == 3) ? I_DN : 9'h0);
      chk("beat_ctrl", 32'(ctrl()), 32'(exp));
      chk("beat_data", to_d ? bus.d_rdata : bus.i_rdata, base + 32'(b));
      chk("beat_other", to_d ? bus.i_rdata : bus.d_rdata, 32'h0);
    end
  endtask

  logic [5:0] wr_pat;
  int         accepted;

  initial begin
    rst            = 1'b1;
    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_wready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    @(negedge clk); #1;
    chk("rst_ctrl", 32'(ctrl()), 32'h0);
    chk("rst_bus", bus.i_rdata | bus.d_rdata | bus.mem_addr | bus.mem_wdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    // I-only refill.
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h1004; #1;
    chk("t1_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t1_addr_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    chk("t1_addr", bus.mem_addr, 32'h1000);
    read_burst(1'b0, 32'hA0);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; #1;
    chk("t1_after", 32'(ctrl()), 32'h0);

    // Simultaneous requests from reset: D first, then I two cycles after d_done.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h3008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h401C; #1;
    chk("t2_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t2_d_addr_ctrl", 32'(ctrl()), 32'(D_GNT | M_REQ));
    chk("t2_d_addr", bus.mem_addr, 32'h4010);
    read_burst(1'b1, 32'hC0);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.d_req = 1'b0; #1;
    chk("t2_turn", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t2_i_addr_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    chk("t2_i_addr", bus.mem_addr, 32'h3000);
    read_burst(1'b0, 32'hB0);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; #1;
    chk("t2_after", 32'(ctrl()), 32'h0);

    // D writeback with stalling mem_wready.
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; #1;
    chk("t3_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t3_addr_ctrl", 32'(ctrl()), 32'(D_GNT | M_REQ | M_WE));
    chk("t3_addr", bus.mem_addr, 32'h2000);
    wr_pat   = 6'b101101;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.mem_wready = wr_pat[k];
      bus.d_wdata    = 32'hD0 + 32'(accepted);
      #1;
      chk("t3_wr_ctrl", 32'(ctrl()),
          32'(M_WE | (wr_pat[k] ? D_WR : 9'h0) | ((k == 5) ? D_DN : 9'h0)));
      chk("t3_wdata", bus.mem_wdata, 32'hD0 + 32'(accepted));
      if (wr_pat[k]) accepted++;
    end
    @(negedge clk); bus.mem_wready = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0; #1;
    chk("t3_after", 32'(ctrl()), 32'h0);

    // D holds req past d_done with I waiting: I wins, no duplicate bursts.
    @(negedge clk); bus.d_req = 1'b1; bus.d_addr = 32'h8000; #1;
    chk("t4_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; bus.i_req = 1'b1; bus.i_addr = 32'h9000; #1;
    chk("t4_d_addr_ctrl", 32'(ctrl()), 32'(D_GNT | M_REQ));
    read_burst(1'b1, 32'h50);
    @(negedge clk); bus.mem_rvalid = 1'b0; #1;
    chk("t4_mask_cycle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.d_req = 1'b0; bus.mem_ack = 1'b1; #1;
    chk("t4_i_addr_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    chk("t4_i_addr", bus.mem_addr, 32'h9000);
    read_burst(1'b0, 32'h60);
    @(negedge clk); bus.mem_rvalid = 1'b0; #1;
    chk("t4_i_hold", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.i_req = 1'b0; #1;
    chk("t4_no_dup", 32'(ctrl()), 32'h0);
    @(negedge clk); #1;
    chk("t4_quiet", 32'(ctrl()), 32'h0);

    // Reset on beat 2 of an I refill, then a fresh full refill.
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h5000; #1;
    chk("t5_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t5_addr_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'h70 + 32'(b); #1;
      chk("t5_beat_ctrl", 32'(ctrl()), 32'(I_RV));
      chk("t5_beat_data", bus.i_rdata, 32'h70 + 32'(b));
    end
    @(negedge clk); bus.mem_rdata = 32'h72; rst = 1'b1; #1;
    chk("t5_rst_ctrl", 32'(ctrl()), 32'h0);
    chk("t5_rst_bus", bus.i_rdata | bus.mem_addr, 32'h0);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; rst = 1'b0; #1;
    chk("t5_post_rst", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h6000; #1;
    chk("t5_re_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_ack = 1'b1; #1;
    chk("t5_re_addr_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    chk("t5_re_addr", bus.mem_addr, 32'h6000);
    read_burst(1'b0, 32'h80);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; #1;
    chk("t5_after", 32'(ctrl()), 32'h0);
    @(negedge clk);

    // Stray mem_rvalid in ADDR before mem_ack is ignored.
    @(negedge clk); bus.i_req = 1'b1; bus.i_addr = 32'h700C; #1;
    chk("t6_idle", 32'(ctrl()), 32'h0);
    @(negedge clk); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hEE; #1;
    chk("t6_stray_ctrl", 32'(ctrl()), 32'(I_GNT | M_REQ));
    chk("t6_stray_data", bus.i_rdata, 32'h0);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.mem_ack = 1'b1; #1;
    chk("t6_ack_ctrl", 32'(ctrl()), 32'(M_REQ));
    chk("t6_addr", bus.mem_addr, 32'h7000);
    read_burst(1'b0, 32'h90);
    @(negedge clk); bus.mem_rvalid = 1'b0; bus.i_req = 1'b0; #1;
    chk("t6_after", 32'(ctrl()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
